// File: rtl/vga_fade_if.sv
// Timing, pixel and faded-output signals between the VGA timer/pixel source and
// the fade output stage.
interface vga_fade_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        visible_in;
    logic [31:0] frame_in;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic        hsync;
    logic        vsync;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [4:0]  level;

    modport master (
        output hsync_in, vsync_in, visible_in, frame_in, r_in, g_in, b_in,
        input  hsync, vsync, r, g, b, level
    );

    modport slave (
        input  hsync_in, vsync_in, visible_in, frame_in, r_in, g_in, b_in,
        output hsync, vsync, r, g, b, level
    );
endinterface

// File: rtl/vga_fade_out.sv
// VGA output stage: aligns sync with the pixel pipeline and applies a frame-driven
// fade-in / hold / fade-out / blank brightness cycle. Define VGA_FADE_DITHER_EN for 2x2 dither.
module vga_fade_out #(
    parameter int PIPE_DEPTH  = 2,
    parameter int STEP_FRAMES = 4,
    parameter int HOLD_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_fade_if.slave  bus
);

    typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT, BLANK} state_t;

    localparam logic [15:0] STEP_LAST = 16'(STEP_FRAMES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

    logic        hs_d, vs_d, vis_d;
    logic [31:0] frame_prev;
    logic        tick;
    state_t      state, state_nx;
    logic [4:0]  level_q, level_nx;
    logic [15:0] cnt, cnt_nx;
    logic [4:0]  level_act;
    logic [3:0]  r_px, g_px, b_px;
    logic        hsync_q, vsync_q;
    logic [3:0]  r_q, g_q, b_q;

    // Timing signals are delayed so they meet the colour coming out of the pixel pipeline.
    generate
        if (PIPE_DEPTH == 0) begin : g_nodly
            assign hs_d  = bus.hsync_in;
            assign vs_d  = bus.vsync_in;
            assign vis_d = bus.visible_in;
        end else begin : g_dly
            logic [PIPE_DEPTH-1:0] hs_sr, vs_sr, vis_sr;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hs_sr  <= '1;
                    vs_sr  <= '1;
                    vis_sr <= '0;
                end else begin
                    hs_sr[0]  <= bus.hsync_in;
                    vs_sr[0]  <= bus.vsync_in;
                    vis_sr[0] <= bus.visible_in;
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        hs_sr[i]  <= hs_sr[i-1];
                        vs_sr[i]  <= vs_sr[i-1];
                        vis_sr[i] <= vis_sr[i-1];
                    end
                end
            end

            assign hs_d  = hs_sr[PIPE_DEPTH-1];
            assign vs_d  = vs_sr[PIPE_DEPTH-1];
            assign vis_d = vis_sr[PIPE_DEPTH-1];
        end
    endgenerate

    assign tick = (bus.frame_in != frame_prev);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_prev <= bus.frame_in;
            state      <= FADE_IN;
            level_q    <= 5'd0;
            cnt        <= 16'd0;
        end else begin
            frame_prev <= bus.frame_in;
            state      <= state_nx;
            level_q    <= level_nx;
            cnt        <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        level_nx = level_q;
        cnt_nx   = cnt;
        if (tick) begin
            case (state)
                FADE_IN: begin
                    if (cnt == STEP_LAST) begin
                        level_nx = level_q + 5'd1;
                        cnt_nx   = 16'd0;
                        if (level_q == 5'd15) state_nx = HOLD;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nx = FADE_OUT;
                        cnt_nx   = 16'd0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                FADE_OUT: begin
                    if (cnt == STEP_LAST) begin
                        level_nx = level_q - 5'd1;
                        cnt_nx   = 16'd0;
                        if (level_q == 5'd1) state_nx = BLANK;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                BLANK: begin
                    state_nx = FADE_IN;
                    cnt_nx   = 16'd0;
                end
                default: begin
                    state_nx = FADE_IN;
                    cnt_nx   = 16'd0;
                end
            endcase
        end
    end

`ifdef VGA_FADE_DITHER_EN
    logic       x_par, y_par, hs_prev;
    logic [3:0] thr;
    logic [7:0] p_r, p_g, p_b;

    // Pixel/line parity selects the ordered-dither threshold for the current pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_par   <= 1'b0;
            y_par   <= 1'b0;
            hs_prev <= 1'b1;
        end else begin
            hs_prev <= hs_d;
            if (!hs_d)      x_par <= 1'b0;
            else if (vis_d) x_par <= ~x_par;
            if (!vs_d)                  y_par <= 1'b0;
            else if (hs_prev && !hs_d)  y_par <= ~y_par;
        end
    end

    always_comb begin
        thr = 4'd0;
        case ({y_par, x_par})
            2'b00: thr = 4'd0;
            2'b01: thr = 4'd8;
            2'b10: thr = 4'd12;
            2'b11: thr = 4'd4;
            default: thr = 4'd0;
        endcase
    end

    function automatic logic [3:0] dither(input logic [7:0] p, input logic [3:0] t,
                                          input logic bypass);
        logic [4:0] q;
        q = 5'(({1'b0, p} + {5'd0, t}) >> 4);
        if (bypass)    return 4'(p >> 4);
        else if (q[4]) return 4'd15;
        else           return q[3:0];
    endfunction

    assign p_r  = {4'd0, bus.r_in} * {3'd0, level_act};
    assign p_g  = {4'd0, bus.g_in} * {3'd0, level_act};
    assign p_b  = {4'd0, bus.b_in} * {3'd0, level_act};
    assign r_px = dither(p_r, thr, (level_act == 5'd0) || (level_act == 5'd16));
    assign g_px = dither(p_g, thr, (level_act == 5'd0) || (level_act == 5'd16));
    assign b_px = dither(p_b, thr, (level_act == 5'd0) || (level_act == 5'd16));
`else
    assign r_px = 4'(({4'd0, bus.r_in} * {3'd0, level_act}) >> 4);
    assign g_px = 4'(({4'd0, bus.g_in} * {3'd0, level_act}) >> 4);
    assign b_px = 4'(({4'd0, bus.b_in} * {3'd0, level_act}) >> 4);
`endif

    // The applied level is only refreshed during vsync so a frame never changes brightness mid-scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            r_q       <= 4'd0;
            g_q       <= 4'd0;
            b_q       <= 4'd0;
            level_act <= 5'd0;
        end else begin
            hsync_q <= hs_d;
            vsync_q <= vs_d;
            r_q     <= vis_d ? r_px : 4'd0;
            g_q     <= vis_d ? g_px : 4'd0;
            b_q     <= vis_d ? b_px : 4'd0;
            if (!vs_d) level_act <= level_q;
        end
    end

    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
    assign bus.r     = r_q;
    assign bus.g     = g_q;
    assign bus.b     = b_q;
    assign bus.level = level_q;

endmodule

// File: tb/tb_vga_fade_out.sv
// Directed bench for vga_fade_out: sync delay, fade level sequence, colour scaling,
// vsync-gated level update and mid-fade reset.
module tb_vga_fade_out;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    bit   hs_pat [1000];
    bit   vs_pat [1000];

    always #5 clk = ~clk;

    vga_fade_if bus ();

    vga_fade_out #(
        .PIPE_DEPTH (2),
        .STEP_FRAMES(1),
        .HOLD_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic hs, input logic vs, input logic vis,
                                  input logic [3:0] rv, input logic [3:0] gv, input logic [3:0] bv);
        bus.hsync_in   = hs;
        bus.vsync_in   = vs;
        bus.visible_in = vis;
        bus.r_in       = rv;
        bus.g_in       = gv;
        bus.b_in       = bv;
    endtask

    task automatic frame_tick();
        bus.frame_in = bus.frame_in + 32'd1;
        step();
    endtask

    // Vsync pulse with blanked pixels, then visible again long enough for colour to settle.
    task automatic vsync_pulse(input logic [3:0] rv, input logic [3:0] gv, input logic [3:0] bv);
        apply_stimulus(1'b1, 1'b0, 1'b0, rv, gv, bv);
        repeat (4) step();
        apply_stimulus(1'b1, 1'b1, 1'b1, rv, gv, bv);
        repeat (6) step();
    endtask

    initial begin
        bus.frame_in = 32'd0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        rst_n = 1'b0;
        step();
        step();
        check_output("reset_hsync", 32'(bus.hsync), 32'd1);
        check_output("reset_vsync", 32'(bus.vsync), 32'd1);
        check_output("reset_r", 32'(bus.r), 32'd0);
        check_output("reset_level", 32'(bus.level), 32'd0);
        rst_n = 1'b1;

        // Constant frame: sync follows inputs three cycles late, colour stays dark.
        for (int i = 0; i < 1000; i++) begin
            if (i >= 3) begin
                check_output("delay_hsync", 32'(bus.hsync), 32'(hs_pat[i-3]));
                check_output("delay_vsync", 32'(bus.vsync), 32'(vs_pat[i-3]));
            end
            if (i % 100 == 50) check_output("dark_r", 32'(bus.r), 32'd0);
            hs_pat[i] = ((i % 7) >= 2);
            vs_pat[i] = ((i % 50) >= 5);
            apply_stimulus(hs_pat[i], vs_pat[i], 1'b1, 4'd15, 4'd15, 4'd15);
            step();
        end
        check_output("const_frame_level", 32'(bus.level), 32'd0);

        // Level sequence over 40 frames with one-frame steps and two-frame hold.
        rst_n = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            int exp_lvl;
            if (k <= 16)      exp_lvl = k;
            else if (k <= 18) exp_lvl = 16;
            else if (k <= 34) exp_lvl = 34 - k;
            else if (k == 35) exp_lvl = 0;
            else              exp_lvl = k - 35;
            frame_tick();
            check_output($sformatf("seq_level_%0d", k), 32'(bus.level), 32'(exp_lvl));
        end
        step();
        check_output("seq_no_tick", 32'(bus.level), 32'd5);

        // Colour scaling at level 8, applied only after a vsync.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'd15, 4'd5, 4'd10);
        repeat (8) frame_tick();
        check_output("lvl8_level", 32'(bus.level), 32'd8);
        repeat (4) step();
        check_output("lvl8_before_vs_r", 32'(bus.r), 32'd0);
        vsync_pulse(4'd15, 4'd5, 4'd10);
        check_output("lvl8_r", 32'(bus.r), 32'd7);
        check_output("lvl8_g", 32'(bus.g), 32'd2);
        check_output("lvl8_b", 32'(bus.b), 32'd5);

        // A tick mid-frame must not change visible colour until the next vsync.
        frame_tick();
        check_output("midvis_level", 32'(bus.level), 32'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("midvis_r_hold", 32'(bus.r), 32'd7);
        end
        vsync_pulse(4'd15, 4'd5, 4'd10);
        check_output("lvl9_r", 32'(bus.r), 32'd8);
        check_output("lvl9_g", 32'(bus.g), 32'd2);
        check_output("lvl9_b", 32'(bus.b), 32'd5);

        // Full brightness passes colour through; blanking forces zero.
        repeat (7) frame_tick();
        check_output("lvl16_level", 32'(bus.level), 32'd16);
        vsync_pulse(4'd15, 4'd5, 4'd10);
        check_output("lvl16_r", 32'(bus.r), 32'd15);
        check_output("lvl16_g", 32'(bus.g), 32'd5);
        check_output("lvl16_b", 32'(bus.b), 32'd10);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd15, 4'd5, 4'd10);
        repeat (4) step();
        check_output("blank_r", 32'(bus.r), 32'd0);
        check_output("blank_g", 32'(bus.g), 32'd0);
        check_output("blank_b", 32'(bus.b), 32'd0);

        // Two hold ticks, then fade out to 9 and reset mid-fade.
        repeat (9) frame_tick();
        check_output("fadeout_level", 32'(bus.level), 32'd9);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'd15, 4'd5, 4'd10);
        repeat (3) step();
        check_output("pre_reset_hsync", 32'(bus.hsync), 32'd0);
        rst_n = 1'b0;
        bus.frame_in = bus.frame_in + 32'd1;
        step();
        check_output("midreset_level", 32'(bus.level), 32'd0);
        check_output("midreset_hsync", 32'(bus.hsync), 32'd1);
        check_output("midreset_vsync", 32'(bus.vsync), 32'd1);
        check_output("midreset_r", 32'(bus.r), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        check_output("reset_tick_ignored", 32'(bus.level), 32'd0);
        frame_tick();
        check_output("after_reset_fadein", 32'(bus.level), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
